// File: rtl/z80_bus_responder_pkg.sv
// Shared types for the z80 bus responder: FSM states, access kinds
// and counter widths.
package z80_bus_responder_pkg;

    localparam int WAIT_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOOT,
        S_WAIT,
        S_ACCESS
    } state_e;

    typedef enum logic [1:0] {
        K_MEM,
        K_IO,
        K_INTA
    } kind_e;

endpackage

// File: rtl/z80_bus_responder_if.sv
// z80 core bus as seen by the memory/I-O responder.
// master = CPU side, slave = responder side.
interface z80_bus_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic              n_mreq;
    logic              n_iorq;
    logic              n_rd;
    logic              n_wr;
    logic              n_m1;
    logic              boot_start;
    logic [7:0]        dout;
    logic              dout_en;
    logic              n_wait;
    logic              boot_busy;
    logic              boot_done;
    logic              bus_err;

    modport master (
        output addr, din, n_mreq, n_iorq, n_rd, n_wr, n_m1, boot_start,
        input  dout, dout_en, n_wait, boot_busy, boot_done, bus_err
    );

    modport slave (
        input  addr, din, n_mreq, n_iorq, n_rd, n_wr, n_m1, boot_start,
        output dout, dout_en, n_wait, boot_busy, boot_done, bus_err
    );
endinterface

// File: rtl/z80_bus_responder_ram.sv
// Single-port byte RAM with synchronous write and registered read.
// Read data only updates when re_i is set, so it holds across a bus cycle.
module z80_sp_ram
    import z80_bus_responder_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/z80_bus_responder.sv
// Memory + I/O responder for the z80 core bus with wait states,
// interrupt-acknowledge vector and a boot byte streamer.
module z80_bus_responder
    import z80_bus_responder_pkg::*;
#(
    parameter int         MEM_AW     = 12,
    parameter int         IO_AW      = 8,
    parameter int         MEM_WAIT   = 0,
    parameter int         IO_WAIT    = 1,
    parameter int         BOOT_BYTES = 4096,
    parameter logic [7:0] INT_VECTOR = 8'hFF,
    parameter int         ADDR_W     = 16
) (
    input logic               clk,
    input logic               reset,
    z80_bus_responder_if.slave bus
);
    localparam int BCNT_W = $clog2(BOOT_BYTES + 1);

    state_e state_q, state_d;
    kind_e  kind_q, kind_d, acc_kind, start_kind;
    logic   wr_q, wr_d, acc_wr, do_acc;

    logic [MEM_AW-1:0] maddr_q, maddr_d, mem_addr;
    logic [IO_AW-1:0]  iaddr_q, iaddr_d, io_addr;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d, wload;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic dout_en_q, dout_en_d;
    logic boot_done_q, boot_done_d;
    logic bus_err_q, bus_err_d;

    logic mem_we, mem_re, io_we, io_re;
    logic [7:0] mem_rdata, io_rdata, dout;
    logic mreq, iorq, rd, wr, inta, clash, start, released;

    // Only the low address bits select a byte; the rest wrap.
    logic [ADDR_W-1:0] unused_addr;
    assign unused_addr = bus.addr;

    assign mreq     = ~bus.n_mreq;
    assign iorq     = ~bus.n_iorq;
    assign rd       = ~bus.n_rd;
    assign wr       = ~bus.n_wr;
    assign inta     = iorq & ~bus.n_m1;
    assign clash    = mreq & iorq & bus.n_m1;
    assign start    = inta | ((mreq ^ iorq) & (rd | wr));
    assign released = bus.n_mreq & bus.n_iorq & bus.n_rd & bus.n_wr;

    assign start_kind = inta ? K_INTA : (iorq ? K_IO : K_MEM);
    assign wload = (start_kind == K_MEM) ? WAIT_W'(MEM_WAIT)
                                         : WAIT_W'(IO_WAIT);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        wr_d        = wr_q;
        maddr_d     = maddr_q;
        iaddr_d     = iaddr_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        dout_en_d   = dout_en_q;
        boot_done_d = 1'b0;
        bus_err_d   = bus_err_q | (clash & (state_q != S_BOOT));
        mem_addr    = maddr_q;
        io_addr     = iaddr_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        io_we       = 1'b0;
        io_re       = 1'b0;
        acc_kind    = kind_q;
        acc_wr      = wr_q;
        do_acc      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.boot_start) begin
                    state_d   = S_BOOT;
                    kind_d    = K_MEM;
                    mem_addr  = '0;
                    mem_re    = 1'b1;
                    bcnt_d    = BCNT_W'(1);
                    dout_en_d = 1'b1;
                end else if (start) begin
                    kind_d   = start_kind;
                    wr_d     = wr & ~inta;
                    maddr_d  = MEM_AW'(bus.addr);
                    iaddr_d  = IO_AW'(bus.addr);
                    mem_addr = maddr_d;
                    io_addr  = iaddr_d;
                    acc_kind = start_kind;
                    acc_wr   = wr_d;
                    if (wload == '0) begin
                        do_acc = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = wload;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - WAIT_W'(1);
                if (wcnt_q <= WAIT_W'(1)) do_acc = 1'b1;
            end
            S_ACCESS: begin
                if (released) begin
                    state_d   = S_IDLE;
                    dout_en_d = 1'b0;
                end
            end
            S_BOOT: begin
                if (bcnt_q == BCNT_W'(BOOT_BYTES)) begin
                    state_d     = S_IDLE;
                    dout_en_d   = 1'b0;
                    boot_done_d = 1'b1;
                end else begin
                    mem_addr = MEM_AW'(bcnt_q);
                    mem_re   = 1'b1;
                    bcnt_d   = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The array is touched exactly once, on the edge that enters ACCESS.
        if (do_acc) begin
            state_d = S_ACCESS;
            if (acc_wr) begin
                mem_we = (acc_kind == K_MEM);
                io_we  = (acc_kind == K_IO);
            end else begin
                dout_en_d = 1'b1;
                mem_re    = (acc_kind == K_MEM);
                io_re     = (acc_kind == K_IO);
            end
        end

        if (reset) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
            io_we  = 1'b0;
            io_re  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= K_MEM;
            wr_q        <= 1'b0;
            maddr_q     <= '0;
            iaddr_q     <= '0;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            dout_en_q   <= 1'b0;
            boot_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            wr_q        <= wr_d;
            maddr_q     <= maddr_d;
            iaddr_q     <= iaddr_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            dout_en_q   <= dout_en_d;
            boot_done_q <= boot_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    z80_sp_ram #(.AW(MEM_AW)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (bus.din),
        .rdata_o (mem_rdata)
    );

    z80_sp_ram #(.AW(IO_AW)) u_io (
        .clk     (clk),
        .we_i    (io_we),
        .re_i    (io_re),
        .addr_i  (io_addr),
        .wdata_i (bus.din),
        .rdata_o (io_rdata)
    );

    always_comb begin
        dout = '0;
        if (dout_en_q) begin
            unique case (kind_q)
                K_MEM:   dout = mem_rdata;
                K_IO:    dout = io_rdata;
                K_INTA:  dout = INT_VECTOR;
                default: dout = '0;
            endcase
        end
    end

    assign bus.dout      = dout;
    assign bus.dout_en   = dout_en_q;
    assign bus.n_wait    = ~((state_q == S_WAIT) && (wcnt_q != '0));
    assign bus.boot_busy = (state_q == S_BOOT);
    assign bus.boot_done = boot_done_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// Randomised bench for z80_bus_responder against a byte-array model
// of memory and I/O space with the expected wait/latency rules.
module tb_z80_bus_responder;
    localparam int MEM_AW     = 12;
    localparam int IO_AW      = 8;
    localparam int MEM_WAIT   = 0;
    localparam int IO_WAIT    = 3;
    localparam int BOOT_BYTES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] mem_m [2**MEM_AW];
    bit         mem_v [2**MEM_AW];
    logic [7:0] io_m  [2**IO_AW];
    bit         io_v  [2**IO_AW];
    int         mem_q [$];
    int         io_q  [$];

    z80_bus_responder_if #(.ADDR_W(16)) bus ();

    z80_bus_responder #(
        .MEM_AW     (MEM_AW),
        .IO_AW      (IO_AW),
        .MEM_WAIT   (MEM_WAIT),
        .IO_WAIT    (IO_WAIT),
        .BOOT_BYTES (BOOT_BYTES),
        .INT_VECTOR (8'hFF),
        .ADDR_W     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.n_mreq     = 1'b1;
        bus.n_iorq     = 1'b1;
        bus.n_rd       = 1'b1;
        bus.n_wr       = 1'b1;
        bus.n_m1       = 1'b1;
        bus.boot_start = 1'b0;
    endtask

    // kind: 0 = memory, 1 = I/O, 2 = interrupt acknowledge
    task automatic xfer(input int kind, input bit wr, input logic [15:0] a,
                        input logic [7:0] d, input string tag);
        int waits, lat, ew, mi, ii;
        logic [7:0] got, expd;
        logic en;
        mi = int'(a[MEM_AW-1:0]);
        ii = int'(a[IO_AW-1:0]);
        ew = (kind == 0) ? MEM_WAIT : IO_WAIT;
        expd = (kind == 2) ? 8'hFF : ((kind == 0) ? mem_m[mi] : io_m[ii]);
        bus.addr   = a;
        bus.din    = d;
        bus.n_m1   = (kind != 2);
        bus.n_mreq = (kind != 0);
        bus.n_iorq = (kind == 0);
        bus.n_rd   = wr;
        bus.n_wr   = !wr;
        waits = 0;
        lat   = 0;
        got   = '0;
        en    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!bus.n_wait) waits++;
            else begin
                en  = bus.dout_en;
                got = bus.dout;
                if (wr || en) break;
            end
        end
        chk({tag, "_waits"}, waits, ew);
        chk({tag, "_latency"}, lat, ew + 1);
        if (!wr) begin
            chk({tag, "_dout_en"}, en, 1);
            chk({tag, "_data"}, got, expd);
        end else begin
            chk({tag, "_wr_dout_en"}, en, 0);
        end
        idle_bus();
        @(negedge clk);
        chk({tag, "_release"}, bus.dout_en, 0);
        if (wr && kind == 0) begin
            if (!mem_v[mi]) mem_q.push_back(mi);
            mem_v[mi] = 1'b1;
            mem_m[mi] = d;
        end
        if (wr && kind == 1) begin
            if (!io_v[ii]) io_q.push_back(ii);
            io_v[ii] = 1'b1;
            io_m[ii] = d;
        end
    endtask

    task automatic boot_run(input string tag);
        bus.boot_start = 1'b1;
        for (int i = 0; i < BOOT_BYTES; i++) begin
            @(negedge clk);
            bus.boot_start = 1'b0;
            chk({tag, "_byte"}, bus.dout, mem_m[i]);
            chk({tag, "_en_busy_done"},
                {bus.dout_en, bus.boot_busy, bus.boot_done}, 3'b110);
        end
        @(negedge clk);
        chk({tag, "_end"},
            {bus.dout_en, bus.boot_busy, bus.boot_done}, 3'b001);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.boot_done, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"}, bus.dout, 0);
        chk({tag, "_flags"},
            {bus.dout_en, bus.n_wait, bus.boot_busy, bus.boot_done,
             bus.bus_err}, 5'b01000);
    endtask

    initial begin
        logic [7:0] img [4];
        logic [15:0] a;
        int  sel, kind;
        bit  wr, seen;
        img = '{8'h3E, 8'h05, 8'h76, 8'h00};
        idle_bus();
        bus.addr = '0;
        bus.din  = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) xfer(0, 1, 16'(i), img[i], "preload");
        boot_run("boot");

        xfer(0, 0, 16'h0002, 8'h00, "mem_rd");
        xfer(1, 1, 16'h1234, 8'hA5, "io_wr");
        xfer(1, 0, 16'hAB34, 8'h00, "io_rd_wrap");
        xfer(2, 0, 16'h0038, 8'h00, "inta");
        xfer(0, 1, 16'hF123, 8'h5C, "mem_wr_wrap");
        xfer(0, 0, 16'h0123, 8'h00, "mem_rd_wrap");
        xfer(0, 1, 16'h0FFF, 8'hC3, "mem_wr_top");
        xfer(0, 0, 16'h1FFF, 8'h00, "mem_rd_top");

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            a   = 16'($urandom);
            if (sel == 9) begin
                xfer(2, 0, a, 8'h00, "rnd_inta");
            end else begin
                kind = (sel < 5) ? 0 : 1;
                wr   = 1'($urandom_range(0, 1));
                if (!wr && kind == 0)
                    a[MEM_AW-1:0] = MEM_AW'(mem_q[$urandom_range(0, mem_q.size() - 1)]);
                if (!wr && kind == 1)
                    a[IO_AW-1:0] = IO_AW'(io_q[$urandom_range(0, io_q.size() - 1)]);
                xfer(kind, wr, a, 8'($urandom), wr ? "rnd_wr" : "rnd_rd");
            end
        end

        boot_run("boot2");

        bus.addr   = 16'h0002;
        bus.din    = 8'h99;
        bus.n_mreq = 1'b0;
        bus.n_iorq = 1'b0;
        bus.n_m1   = 1'b1;
        bus.n_wr   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("clash_idle", {bus.dout_en, bus.n_wait}, 2'b01);
        end
        chk("clash_err", bus.bus_err, 1);
        idle_bus();
        repeat (2) @(negedge clk);
        chk("clash_err_sticky", bus.bus_err, 1);
        xfer(0, 0, 16'h0002, 8'h00, "clash_nowrite");
        chk("clash_err_kept", bus.bus_err, 1);

        bus.boot_start = 1'b1;
        @(negedge clk);
        bus.boot_start = 1'b0;
        @(negedge clk);
        chk("rst_boot_byte1", bus.dout, mem_m[1]);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_boot");
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.boot_done;
        end
        chk("rst_boot_no_done", seen, 0);

        bus.addr   = 16'h0034;
        bus.din    = 8'h5A;
        bus.n_iorq = 1'b0;
        bus.n_wr   = 1'b0;
        @(negedge clk);
        chk("rst_wr_waiting", bus.n_wait, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_bus();
        @(negedge clk);
        chk_reset_vals("rst_wr");
        reset = 1'b0;
        @(negedge clk);
        xfer(1, 0, 16'h0034, 8'h00, "rst_wr_unchanged");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
